// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then ten inverse rounds with the key schedule unwound on the fly.
// Optional macro AES_KEY_CACHE_EN keeps the last key and its rk10 so a repeated key skips the expansion phase.
module aes_inv_cipher #(
    parameter int NR = 10
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher supports only NR = 10 (AES-128)");
    end

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

    state_t       state, next_state;
    logic [127:0] blk, rkey;
    logic [3:0]   cnt;
    logic         cache_hit;
    logic [127:0] hit_rk;
    logic [31:0]  rot, sw_in, sw_out, rc;
    logic [31:0]  fw0, fw1, fw2, fw3, iw0, iw1, iw2, iw3;
    logic [127:0] fwd_key, prev_key, isr, added, mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        r = '0;
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        return r;
    endfunction

`ifdef AES_KEY_CACHE_EN
    logic [127:0] cache_key, cache_rk;
    logic         cache_vld;
    assign cache_hit = cache_vld && (AES_key_in == cache_key);
    assign hit_rk    = cache_rk;
`else
    assign cache_hit = 1'b0;
    assign hit_rk    = '0;
`endif

    // One SubWord unit serves both schedule directions; ROUND feeds it the recovered w3
    always_comb begin
        iw3    = rkey[31:0]  ^ rkey[63:32];
        iw2    = rkey[63:32] ^ rkey[95:64];
        iw1    = rkey[95:64] ^ rkey[127:96];
        sw_in  = (state == ROUND) ? iw3 : rkey[31:0];
        rot    = {sw_in[23:0], sw_in[31:24]};
        sw_out = '0;
        for (int b = 0; b < 4; b++) sw_out[31-8*b -: 8] = sbox(rot[31-8*b -: 8]);
        rc       = {rcon((state == ROUND) ? cnt - 4'd1 : cnt), 24'h000000};
        fw0      = rkey[127:96] ^ sw_out ^ rc;
        fw1      = rkey[95:64] ^ fw0;
        fw2      = rkey[63:32] ^ fw1;
        fw3      = rkey[31:0]  ^ fw2;
        fwd_key  = {fw0, fw1, fw2, fw3};
        iw0      = rkey[127:96] ^ sw_out ^ rc;
        prev_key = {iw0, iw1, iw2, iw3};
    end

    always_comb begin
        isr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isr[127-8*(4*c+r) -: 8] = inv_sbox(blk[127-8*(4*((c+4-r)%4)+r) -: 8]);
        added = isr ^ prev_key;
        mixed = added;
        if (cnt != 4'd1)
            for (int c = 0; c < 4; c++) mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (AES_en) next_state = cache_hit ? INIT : KEYEXP;
            KEYEXP:  if (cnt == 4'd9) next_state = INIT;
            INIT:    next_state = ROUND;
            ROUND:   if (cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            blk                <= '0;
            rkey               <= '0;
            cnt                <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            cache_key          <= '0;
            cache_rk           <= '0;
            cache_vld          <= 1'b0;
`endif
        end else begin
            AES_data_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    AES_busy <= AES_en;
                    if (AES_en) begin
                        blk  <= AES_data_in;
                        rkey <= cache_hit ? hit_rk : AES_key_in;
                        cnt  <= cache_hit ? 4'd10 : 4'd0;
`ifdef AES_KEY_CACHE_EN
                        if (!cache_hit) begin
                            cache_key <= AES_key_in;
                            cache_vld <= 1'b0;
                        end
`endif
                    end
                end
                KEYEXP: begin
                    rkey <= fwd_key;
                    cnt  <= cnt + 4'd1;
`ifdef AES_KEY_CACHE_EN
                    if (cnt == 4'd9) begin
                        cache_rk  <= fwd_key;
                        cache_vld <= 1'b1;
                    end
`endif
                end
                INIT: blk <= blk ^ rkey;
                ROUND: begin
                    blk  <= mixed;
                    rkey <= prev_key;
                    cnt  <= cnt - 4'd1;
                end
                DONE: begin
                    AES_data_out       <= blk;
                    AES_data_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, random blocks against a table-based AES model,
// busy/ignore, back-to-back, reset abort and (with AES_KEY_CACHE_EN) the key cache.
module tb_aes_inv_cipher;
    logic         clk, rst_n, en;
    logic [127:0] din, kin, dout;
    logic         dvalid, busy;

    int checks = 0;
    int errors = 0;

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic [7:0]   sbox_t [256];
    logic [7:0]   inv_t  [256];
    bit           cache_vld_m;
    logic [127:0] cache_key_m;

    aes_inv_cipher #(.NR(10)) dut (
        .AES_clk(clk), .AES_rst_n(rst_n), .AES_en(en),
        .AES_data_in(din), .AES_key_in(kin),
        .AES_data_out(dout), .AES_data_out_valid(dvalid), .AES_busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic init_tables();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        rk = round_key(key, 0);
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[127-8*n -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    s[4*c+i] = (rnd == 10) ? t[4*c+i] :
                               gm(t[4*c+i], 8'h02) ^ gm(t[4*c+(i+1)%4], 8'h03) ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
            rk = round_key(key, rnd);
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        rk = round_key(key, 10);
        for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ rk[127-8*n -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            rk = round_key(key, rnd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = inv_t[s[4*((c+4-r)%4)+r]] ^ rk[127-8*(4*c+r) -: 8];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    s[4*c+i] = (rnd == 0) ? t[4*c+i] :
                               gm(t[4*c+i], 8'h0e) ^ gm(t[4*c+(i+1)%4], 8'h0b) ^
                               gm(t[4*c+(i+2)%4], 8'h0d) ^ gm(t[4*c+(i+3)%4], 8'h09);
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] key);
        return (CACHE_ON && cache_vld_m && key == cache_key_m) ? 12 : 22;
    endfunction

    task automatic note_done(input logic [127:0] key);
        if (exp_lat(key) == 22) begin
            cache_key_m = key;
            cache_vld_m = 1'b1;
        end
    endtask

    // ---------------- stimulus helper (no checking) ----------------
    task automatic do_op(input logic [127:0] ct, input logic [127:0] key,
                         output logic [127:0] res, output int lat, output int pulses);
        res = '0; lat = 0; pulses = 0;
        @(negedge clk); din = ct; kin = key; en = 1'b1;
        @(negedge clk); en = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
        kin = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (dvalid) begin
                pulses++;
                if (lat == 0) begin lat = k; res = dout; end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (dout !== 128'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", dvalid); end
    endtask

    task automatic test_known_vectors();
        logic [127:0] res; int lat, pulses, el;
        el = exp_lat(C1_KEY);
        do_op(C1_CT, C1_KEY, res, lat, pulses); note_done(C1_KEY);
        checks++; if (res !== C1_PT) begin errors++; $display("FAIL c1_data: got %h want %h", res, C1_PT); end
        checks++; if (lat !== el) begin errors++; $display("FAIL c1_latency: got %0d want %0d", lat, el); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL c1_pulses: got %0d want 1", pulses); end
        el = exp_lat(B_KEY);
        do_op(B_CT, B_KEY, res, lat, pulses); note_done(B_KEY);
        checks++; if (res !== B_PT) begin errors++; $display("FAIL b_data: got %h want %h", res, B_PT); end
        checks++; if (lat !== el) begin errors++; $display("FAIL b_latency: got %0d want %0d", lat, el); end
    endtask

    task automatic test_round_trip();
        logic [127:0] key, pt, ct, res; int lat, pulses, el;
        key = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        pt  = 128'h000000a5000000000000000000000000;
        ct  = model_encrypt(pt, key);
        el  = exp_lat(key);
        do_op(ct, key, res, lat, pulses); note_done(key);
        checks++; if (res !== pt) begin errors++; $display("FAIL round_trip_data: got %h want %h", res, pt); end
        checks++; if (lat !== el) begin errors++; $display("FAIL round_trip_latency: got %0d want %0d", lat, el); end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, res, expv; int lat, pulses, el;
        for (int i = 0; i < 6; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 0) begin
                expv = {$urandom, $urandom, $urandom, $urandom};
                ct   = model_encrypt(expv, key);
            end else begin
                ct   = {$urandom, $urandom, $urandom, $urandom};
                expv = model_decrypt(ct, key);
            end
            el = exp_lat(key);
            do_op(ct, key, res, lat, pulses); note_done(key);
            checks++; if (res !== expv) begin errors++; $display("FAIL random_data[%0d]: got %h want %h", i, res, expv); end
            checks++; if (lat !== el) begin errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, el); end
        end
    endtask

    task automatic test_busy();
        logic [127:0] res; int lat, pulses, first_k; logic want;
        lat = exp_lat(C1_KEY); pulses = 0; first_k = 0; res = '0;
        @(negedge clk); din = C1_CT; kin = C1_KEY; en = 1'b1;
        @(negedge clk); en = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            want = (k <= lat);
            checks++; if (busy !== want) begin errors++; $display("FAIL busy_cycle%0d: got %b want %b", k, busy, want); end
            if (dvalid) begin
                pulses++;
                if (first_k == 0) begin first_k = k; res = dout; end
            end
            if (k == 4) begin en = 1'b1; din = ~C1_CT; kin = ~C1_KEY; end
            if (k == 5) en = 1'b0;
        end
        note_done(C1_KEY);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
        checks++; if (first_k !== lat) begin errors++; $display("FAIL busy_latency: got %0d want %0d", first_k, lat); end
        checks++; if (res !== C1_PT) begin errors++; $display("FAIL busy_data: got %h want %h", res, C1_PT); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1, k2, p1, p2, c1, c2, r1, r2; int l1, l2, t1, t2, pulses;
        k1 = {$urandom, $urandom, $urandom, $urandom}; p1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom}; p2 = {$urandom, $urandom, $urandom, $urandom};
        c1 = model_encrypt(p1, k1); c2 = model_encrypt(p2, k2);
        l1 = exp_lat(k1); note_done(k1);
        l2 = exp_lat(k2); note_done(k2);
        t1 = 0; t2 = 0; pulses = 0; r1 = '0; r2 = '0;
        @(negedge clk); din = c1; kin = k1; en = 1'b1;
        for (int k = 0; k <= l1 + l2 + 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin din = c2; kin = k2; end
            if (k == l1 + 1) en = 1'b0;
            if (dvalid) begin
                pulses++;
                if (t1 == 0) begin t1 = k; r1 = dout; end
                else if (t2 == 0) begin t2 = k; r2 = dout; end
            end
        end
        en = 1'b0;
        checks++; if (t1 !== l1) begin errors++; $display("FAIL b2b_first_time: got %0d want %0d", t1, l1); end
        checks++; if (r1 !== p1) begin errors++; $display("FAIL b2b_first_data: got %h want %h", r1, p1); end
        checks++; if (t2 !== l1 + 1 + l2) begin errors++; $display("FAIL b2b_second_time: got %0d want %0d", t2, l1 + 1 + l2); end
        checks++; if (r2 !== p2) begin errors++; $display("FAIL b2b_second_data: got %h want %h", r2, p2); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_reset_abort();
        logic [127:0] res; int lat, pulses, el, abort_k;
        abort_k = exp_lat(C1_KEY) - 7;
        @(negedge clk); din = C1_CT; kin = C1_KEY; en = 1'b1;
        @(negedge clk); en = 1'b0;
        for (int k = 1; k <= abort_k; k++) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        cache_vld_m = 1'b0;
        checks++; if (dout !== 128'h0) begin errors++; $display("FAIL abort_dout: got %h want 0", dout); end
        checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", dvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (dvalid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d want 0", pulses); end
        el = exp_lat(C1_KEY);
        do_op(C1_CT, C1_KEY, res, lat, pulses); note_done(C1_KEY);
        checks++; if (res !== C1_PT) begin errors++; $display("FAIL abort_rerun_data: got %h want %h", res, C1_PT); end
        checks++; if (lat !== el) begin errors++; $display("FAIL abort_rerun_latency: got %0d want %0d", lat, el); end
    endtask

`ifdef AES_KEY_CACHE_EN
    task automatic test_key_cache();
        logic [127:0] res; int lat, pulses;
        do_op(C1_CT, C1_KEY, res, lat, pulses); note_done(C1_KEY);
        do_op(C1_CT, C1_KEY, res, lat, pulses); note_done(C1_KEY);
        checks++; if (lat !== 12) begin errors++; $display("FAIL cache_hit_latency: got %0d want 12", lat); end
        checks++; if (res !== C1_PT) begin errors++; $display("FAIL cache_hit_data: got %h want %h", res, C1_PT); end
        do_op(B_CT, B_KEY, res, lat, pulses); note_done(B_KEY);
        checks++; if (lat !== 22) begin errors++; $display("FAIL cache_miss_latency: got %0d want 22", lat); end
        checks++; if (res !== B_PT) begin errors++; $display("FAIL cache_miss_data: got %h want %h", res, B_PT); end
        do_op(B_CT, B_KEY, res, lat, pulses); note_done(B_KEY);
        checks++; if (lat !== 12) begin errors++; $display("FAIL cache_rehit_latency: got %0d want 12", lat); end
    endtask
`endif

    initial begin
        clk = 1'b0; rst_n = 1'b0; en = 1'b0; din = '0; kin = '0;
        cache_vld_m = 1'b0; cache_key_m = '0;
        init_tables();
        repeat (3) @(negedge clk);
        test_reset();
        test_known_vectors();
        test_round_trip();
        test_random();
        test_busy();
        test_back_to_back();
        test_reset_abort();
`ifdef AES_KEY_CACHE_EN
        test_key_cache();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
